// File: rtl/buffered_router.sv
// Single-input router feeding NUM_PORTS independent first-word-fall-through FIFOs.
// Illegal destinations are consumed, dropped and counted in a saturating error counter.
module buffered_router #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int ADDR_WIDTH = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           din,
  input  logic                            din_en,
  input  logic [ADDR_WIDTH-1:0]           addr,
  output logic                            din_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] dout,
  output logic [NUM_PORTS-1:0]            dout_valid,
  input  logic [NUM_PORTS-1:0]            dout_ready,
  output logic [7:0]                      err_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NUM_PORTS-1:0] addr_dec;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;
  logic                 addr_legal;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    addr_dec = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      addr_dec[p] = (addr == ADDR_WIDTH'(p));
    end
  end

  // An address that decodes to no port is always accepted so it can be dropped.
  assign addr_legal = |addr_dec;
  assign din_ready  = !addr_legal || !(|(addr_dec & full));

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    assign full[g]       = (count == CNT_W'(FIFO_DEPTH));
    assign dout_valid[g] = (count != '0);
    assign push[g]       = din_en && din_ready && addr_dec[g];
    assign pop[g]        = dout_valid[g] && dout_ready[g];

    // Head word is gated by valid, so unreset storage never reaches the port.
    assign dout[g*DATA_WIDTH +: DATA_WIDTH] = dout_valid[g] ? mem[rd_ptr] : '0;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[g]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[g])  rd_ptr <= rd_ptr + 1'b1;
        if (push[g] && !pop[g]) begin
          count <= count + 1'b1;
        end else if (pop[g] && !push[g]) begin
          count <= count - 1'b1;
        end
      end
    end

    // NOTE: storage is deliberately not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
      if (push[g] && !rst) mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (din_en && !addr_legal && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: doc/buffered_router.md
BUFFERED_ROUTER -- requirements
Module: buffered_router

Interface
REQ-001 Parameter DATA_WIDTH, default 32, payload width in bits.
REQ-002 Parameter NUM_PORTS, default 4, output channel count; legal range 2..16.
REQ-003 Parameter FIFO_DEPTH, default 4, entries per output FIFO; power of two, at least 2.
REQ-004 Derived localparam ADDR_WIDTH = max(1, clog2(NUM_PORTS)); not overridable.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 din  input  DATA_WIDTH  input payload.
REQ-008 din_en  input  1  input valid.
REQ-009 addr  input  ADDR_WIDTH  destination port index.
REQ-010 din_ready  output  1  input may be accepted this cycle.
REQ-011 dout  output  NUM_PORTS*DATA_WIDTH  flattened outputs; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
REQ-012 dout_valid  output  NUM_PORTS  per-port output valid.
REQ-013 dout_ready  input  NUM_PORTS  per-port consumer ready.
REQ-014 err_cnt  output  8  saturating count of dropped illegal-address inputs.

Function
REQ-015 Each output port SHALL have a private FIFO of FIFO_DEPTH entries with first-word fall-through.
REQ-016 Input accept: a word SHALL be accepted when din_en && din_ready on a rising edge.
- On accept with addr < NUM_PORTS, din SHALL be written to FIFO[addr].
REQ-017 din_ready SHALL be combinational: 1 when addr >= NUM_PORTS, else !full[addr]; it SHALL NOT depend on din_en or dout_ready.
REQ-018 A word accepted at edge N SHALL appear on dout port addr, with dout_valid[addr]=1, from cycle N+1; write-to-output latency is exactly 1 cycle.
REQ-019 Output handshake: FIFO[p] SHALL pop on an edge where dout_valid[p] && dout_ready[p].
- dout port p SHALL hold its head word stable while dout_valid[p] && !dout_ready[p].
REQ-020 dout port p SHALL be all-zero whenever dout_valid[p]=0; a non-valid port never drives stale data.
REQ-021 Per-FIFO ordering SHALL be strict FIFO; no ordering is implied across ports.
REQ-022 Ports SHALL be independent: a full or stalled port SHALL NOT block input words addressed to other ports.
REQ-023 Simultaneous push and pop on the same FIFO SHALL both take effect.
- Occupancy is unchanged.
- Empty case: the pushed word becomes visible next cycle, no bypass.
REQ-024 Full: full[p] SHALL assert when occupancy = FIFO_DEPTH.
- A pop in the same cycle SHALL NOT make din_ready high; no push-through-full.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH.
- Occupancy SHALL be tracked with a counter of clog2(FIFO_DEPTH)+1 bits, so full and empty are distinguishable.
REQ-026 Illegal address (addr >= NUM_PORTS, only possible when NUM_PORTS is not a power of two):
- The word SHALL be consumed (din_ready=1) and discarded.
- err_cnt SHALL increment by 1, saturating at 255.
REQ-027 din_en=0 SHALL leave all FIFOs and err_cnt unchanged, regardless of addr and din.

Reset
REQ-028 With rst=1 at a rising edge, the following SHALL be set:
- All FIFO pointers and occupancies to 0.
- dout_valid to all-zero.
- dout to all-zero.
- err_cnt to 0.
REQ-029 rst SHALL take priority over any simultaneous push or pop; in-flight words are discarded and no handshake completes on that edge.
REQ-030 During rst=1, din_ready SHALL still follow REQ-017 on post-reset state (empty FIFOs, so 1); words presented then are not stored.
REQ-031 FIFO storage arrays need not be reset; no output SHALL depend on unreset storage.

Verification
REQ-032 Defaults, rst released; din=0xDEADBEEF, addr=2, din_en=1 for one cycle; dout_ready=4'b0000.
- Next cycle: dout_valid=4'b0100, port 2 = 0xDEADBEEF, ports 0, 1, 3 = 0.
- Holds until dout_ready[2]=1, then clears one cycle later.
REQ-033 Fill port 1: 4 pushes 0x1..0x4 with dout_ready[1]=0.
- din_ready=0 for addr=1 after the 4th push; 5th word 0x5 is not accepted.
- din_ready=1 for addr=0 and a push there succeeds.
- Releasing dout_ready[1] drains 0x1, 0x2, 0x3, 0x4 in order on consecutive cycles.
REQ-034 Port 3, occupancy 2, dout_ready[3]=1 and push 0xA5 on the same edge:
- Occupancy stays 2.
- Output sequence continues with the older word, then 0xA5.
REQ-035 NUM_PORTS=3: addr=3, din_en=1 for 300 cycles.
- din_ready=1 throughout; no dout_valid asserts.
- err_cnt reaches 255 and holds.
REQ-036 Ports 0 and 2 holding data; assert rst one cycle mid-stream while pushing 0x77 to port 0.
- Next cycle: dout_valid=0, dout=0, err_cnt=0.
- 0x77 is never output.
REQ-037 Random traffic 10k cycles, all ports, random dout_ready, compared against a per-port queue model:
- No loss, duplication or reorder.
- dout is zero whenever its valid is low.
